// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (skid buffer) with valid/ready on
// both sides, state-only ready/valid outputs and a synchronous flush.
module pipe_skid_reg #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b10
    } state_e;

    state_e       state_q;
    state_e       state_d;
    logic [N-1:0] main_q;
    logic [N-1:0] main_d;
    logic [N-1:0] skid_q;
    logic [N-1:0] skid_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // State register; reset clears occupancy immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: occupancy follows accept/deliver; flush and bad codes empty it
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) state_d = S_BUSY;
                end
                S_BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_d = S_FULL;
                    end else if (!in_fire && out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) state_d = S_BUSY;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
        case (state_q)
            S_BUSY: begin
                out_valid = 1'b1;
                count     = 2'd1;
            end
            S_FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
        endcase
    end

    // Datapath steering: fill main first, spill into skid, refill main from skid
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!flush) begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) main_d = in_data;
                end
                S_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d = in_data;
                    end
                end
                S_FULL: begin
                    if (out_fire) main_d = skid_q;
                end
                default: begin
                    main_d = main_q;
                    skid_d = skid_q;
                end
            endcase
        end
    end

    // Data registers; cleared on reset, left untouched by flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifndef SYNTHESIS
    // A stalled head word must not change under the consumer
    a_hold: assert property (
        @(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> $stable(out_data)
    );

    // Occupancy never exceeds two entries
    a_count: assert property (
        @(posedge clk) disable iff (reset) (count != 2'd3)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a capacity-2 queue model predicts
// every handshake output and the order of delivered words.
module tb_pipe_skid_reg;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   count;

    logic [N-1:0] exp_q[$];
    logic         cap_push;
    logic [N-1:0] cap_data;
    int           n_checks;
    int           n_fail;

    pipe_skid_reg #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and hold for one cycle
    task automatic step(input logic v, input logic [N-1:0] d,
                        input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Offer a word until the buffer takes it, bounded
    task automatic send_hold(input logic [N-1:0] d, input logic r);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = r;
            flush     = 1'b0;
            acc       = in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    // Input side: record the word the upcoming edge will accept
    always @(negedge clk) begin
        if (!reset) begin
            cap_push = in_valid && in_ready && !flush;
            cap_data = in_data;
        end else begin
            cap_push = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (cap_push && !reset) exp_q.push_back(cap_data);
    end

    // Output side: compare visible state, then retire the delivered word
    always @(negedge clk) begin
        int sz;
        if (!reset) begin
            sz = exp_q.size();
            check("out_valid", 64'(out_valid), (sz != 0) ? 64'd1 : 64'd0);
            check("in_ready", 64'(in_ready), (sz < 2) ? 64'd1 : 64'd0);
            check("count", 64'(count), 64'(sz));
            if (out_valid && sz != 0) begin
                check("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cap_push  = 1'b0;
        cap_data  = '0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        send_hold(64'hA, 1'b0);
        send_hold(64'hB, 1'b0);
        step(1'b1, 64'hC, 1'b0, 1'b0);
        check("bp_count", 64'(count), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        send_hold(64'hC, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 64'd5, 1'b0, 1'b0);
        step(1'b1, 64'd6, 1'b1, 1'b0);
        check("sim_data", out_data, 64'd6);
        check("sim_count", 64'(count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 64'd7, 1'b0, 1'b0);
        step(1'b1, 64'd8, 1'b0, 1'b0);
        step(1'b1, 64'd9, 1'b0, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step(1'b1, 64'd1, 1'b0, 1'b0);
        step(1'b1, 64'd2, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 64'hAA, 1'b0, 1'b0);
        step(1'b1, 64'hBB, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_data", out_data, 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        check("post_rst_data", out_data, 64'h1234_5678_9ABC_DEF0);
        step(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
